alu_seq_ctrl: RTL and testbench

Multi-cycle sequencer that fronts the shared 2-bit-op ALU path: it accepts one ALU request at a time over a valid/ready handshake and executes it. Add and subtract complete in a single cycle. Multiply uses an iterative shift-add and divide uses iterative restoring division. The result is returned over a second valid/ready handshake, and the block publishes the 3-bit ALU control code for the operation in flight.

---
 rtl/alu_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the shared ALU path: one request at a time, single-cycle add/sub,
// iterative shift-add multiply and restoring divide, result returned over valid/ready.
module alu_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_rem,
    output logic             rsp_divz,
    output logic [2:0]       alu_ctrl,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // EXEC  | single-cycle add/sub
    // MUL   | shift-add multiply, one multiplier bit per cycle
    // DIV   | restoring divide (or one-cycle divide-by-zero)
    // DONE  | response held until consumed
    typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             last;

    // a doubles as multiplicand (shifted left) and as dividend/quotient shift register
    always_comb begin
        mul_acc  = acc + (b[0] ? a : '0);
        rem_sh   = {acc, a[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b};
        if (rem_diff[WIDTH]) begin
            div_rem = rem_sh[WIDTH-1:0];
            div_quo = {a[WIDTH-2:0], 1'b0};
        end else begin
            div_rem = rem_diff[WIDTH-1:0];
            div_quo = {a[WIDTH-2:0], 1'b1};
        end
        last = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= '0;
            a          <= '0;
            b          <= '0;
            acc        <= '0;
            cnt        <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_rem    <= '0;
            rsp_divz   <= 1'b0;
            alu_ctrl   <= 3'b000;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op        <= req_op;
                        a         <= req_a;
                        b         <= req_b;
                        acc       <= '0;
                        cnt       <= '0;
                        alu_ctrl  <= {1'b0, req_op};
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        case (req_op)
                            2'b10:   state <= MUL;
                            2'b11:   state <= DIV;
                            default: state <= EXEC;
                        endcase
                    end
                end
                EXEC: begin
                    rsp_result <= op[0] ? (a - b) : (a + b);
                    rsp_rem    <= '0;
                    rsp_divz   <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= DONE;
                end
                MUL: begin
                    acc <= mul_acc;
                    a   <= a << 1;
                    b   <= b >> 1;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        rsp_result <= mul_acc;
                        rsp_rem    <= '0;
                        rsp_divz   <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DIV: begin
                    if (b == '0) begin
                        rsp_result <= '1;
                        rsp_rem    <= a;
                        rsp_divz   <= 1'b1;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        acc <= div_rem;
                        a   <= div_quo;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            rsp_result <= div_quo;
                            rsp_rem    <= div_rem;
                            rsp_divz   <= 1'b0;
                            rsp_valid  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        alu_ctrl  <= 3'b000;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomised self-checking bench for alu_seq_ctrl against an arithmetic reference model.
module tb_alu_seq_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic [W-1:0] rsp_rem;
    logic         rsp_divz;
    logic [2:0]   alu_ctrl;
    logic         busy;

    int errors = 0;
    int checks = 0;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_rem(rsp_rem), .rsp_divz(rsp_divz),
        .alu_ctrl(alu_ctrl), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic plus expected latency and accept-to-accept gap
    task automatic ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic [W-1:0] rem, output logic dz,
                          output int lat, output int gap);
        logic [2*W-1:0] p;
        rem = '0;
        dz  = 1'b0;
        lat = 1;
        case (op)
            2'b00: res = a + b;
            2'b01: res = a - b;
            2'b10: begin p = a * b; res = p[W-1:0]; lat = W; end
            default: begin
                if (b == '0) begin res = '1; rem = a; dz = 1'b1; end
                else begin res = a / b; rem = a % b; lat = W; end
            end
        endcase
        gap = lat + 2;
    endtask

    // Issues one request from a negedge, waits for the response, optionally consumes it
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic hs, output int lat, output logic [W-1:0] res,
                          output logic [W-1:0] rem, output logic dz,
                          output logic [2:0] ctrl, output logic bsy);
        int guard = 0;
        while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_a = W'($urandom); req_b = W'($urandom); req_op = 2'($urandom);
        ctrl = alu_ctrl;
        bsy  = busy;
        lat  = 0;
        while (!rsp_valid && lat < 200) begin @(posedge clk); lat++; @(negedge clk); end
        res = rsp_result; rem = rsp_rem; dz = rsp_divz;
        if (hs) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] r, m; logic dz, bsy; logic [2:0] c; int lat;
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_rem, rsp_divz, alu_ctrl, busy, req_ready} !== {1'b0, W'(0), W'(0), 1'b0, 3'b000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_initial got valid=%b res=%h rem=%h dz=%b ctrl=%b busy=%b rdy=%b", rsp_valid, rsp_result, rsp_rem, rsp_divz, alu_ctrl, busy, req_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b01, 16'h0009, 16'h0002, 1'b1, lat, r, m, dz, c, bsy);
        req_valid = 1'b1; req_op = 2'b10; req_a = 16'h0FF3; req_b = 16'hF00F;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_result, rsp_rem, rsp_divz, alu_ctrl, busy, req_ready} !== {1'b0, W'(0), W'(0), 1'b0, 3'b000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_mid_mul got valid=%b res=%h rem=%h dz=%b ctrl=%b busy=%b rdy=%b exp all zero rdy=1", rsp_valid, rsp_result, rsp_rem, rsp_divz, alu_ctrl, busy, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 16'd3, 16'd4, 1'b1, lat, r, m, dz, c, bsy);
        checks++;
        if (r !== 16'd7 || lat !== 1) begin
            errors++; $display("FAIL reset_then_add got res=%0d lat=%0d exp res=7 lat=1", r, lat);
        end
    endtask

    task automatic test_addsub();
        logic [W-1:0] r, m, er, em; logic dz, edz, bsy; logic [2:0] c; int lat, elat, gap;
        run_op(2'b00, 16'hFFFF, 16'h0002, 1'b1, lat, r, m, dz, c, bsy);
        checks++;
        if (r !== 16'h0001) begin errors++; $display("FAIL add_wrap result got=%h exp=0001", r); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
        run_op(2'b01, 16'h0000, 16'h0001, 1'b1, lat, r, m, dz, c, bsy);
        checks++;
        if (r !== 16'hFFFF || m !== '0 || dz !== 1'b0) begin errors++; $display("FAIL sub_wrap got res=%h rem=%h dz=%b exp FFFF/0000/0", r, m, dz); end
        checks++;
        if (c !== 3'b001 || bsy !== 1'b1) begin errors++; $display("FAIL sub_ctrl got ctrl=%b busy=%b exp 001/1", c, bsy); end
        for (int i = 0; i < 6; i++) begin
            logic [1:0] op;
            logic [W-1:0] a, b;
            op = 2'(i % 2); a = W'($urandom); b = W'($urandom);
            ref_op(op, a, b, er, em, edz, elat, gap);
            run_op(op, a, b, 1'b1, lat, r, m, dz, c, bsy);
            checks++;
            if (r !== er || m !== em || dz !== edz || lat !== elat || c !== {1'b0, op}) begin
                errors++; $display("FAIL addsub_rand op=%0d a=%h b=%h got res=%h rem=%h dz=%b lat=%0d ctrl=%b exp res=%h rem=%h dz=%b lat=%0d", op, a, b, r, m, dz, lat, c, er, em, edz, elat);
            end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] r, m, er, em; logic dz, edz, bsy; logic [2:0] c; int lat, elat, gap;
        run_op(2'b10, 16'h00FF, 16'h0101, 1'b1, lat, r, m, dz, c, bsy);
        checks++;
        if (r !== 16'hFFFF || lat !== 16) begin errors++; $display("FAIL mul_ff_101 got res=%h lat=%0d exp FFFF lat=16", r, lat); end
        run_op(2'b10, 16'h1234, 16'h0100, 1'b1, lat, r, m, dz, c, bsy);
        checks++;
        if (r !== 16'h3400 || m !== '0) begin errors++; $display("FAIL mul_trunc got res=%h rem=%h exp 3400/0000", r, m); end
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom); b = (i == 0) ? 16'hFFFF : W'($urandom);
            ref_op(2'b10, a, b, er, em, edz, elat, gap);
            run_op(2'b10, a, b, 1'b1, lat, r, m, dz, c, bsy);
            checks++;
            if (r !== er || m !== em || dz !== edz || lat !== elat || c !== 3'b010) begin
                errors++; $display("FAIL mul_rand a=%h b=%h got res=%h rem=%h lat=%0d ctrl=%b exp res=%h lat=%0d", a, b, r, m, lat, c, er, elat);
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] r, m, er, em; logic dz, edz, bsy; logic [2:0] c; int lat, elat, gap;
        run_op(2'b11, 16'd1000, 16'd7, 1'b1, lat, r, m, dz, c, bsy);
        checks++;
        if (r !== 16'd142 || m !== 16'd6 || dz !== 1'b0 || lat !== 16) begin
            errors++; $display("FAIL div_1000_7 got q=%0d r=%0d dz=%b lat=%0d exp 142/6/0 lat=16", r, m, dz, lat);
        end
        run_op(2'b11, 16'd5, 16'd0, 1'b1, lat, r, m, dz, c, bsy);
        checks++;
        if (r !== 16'hFFFF || m !== 16'd5 || dz !== 1'b1 || lat !== 1) begin
            errors++; $display("FAIL div_by_zero got q=%h r=%0d dz=%b lat=%0d exp FFFF/5/1 lat=1", r, m, dz, lat);
        end
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            case (i % 4)
                0: b = W'($urandom_range(1, 15));
                1: b = W'($urandom);
                2: b = a;
                default: b = 16'hFFFF;
            endcase
            ref_op(2'b11, a, b, er, em, edz, elat, gap);
            run_op(2'b11, a, b, 1'b1, lat, r, m, dz, c, bsy);
            checks++;
            if (r !== er || m !== em || dz !== edz || lat !== elat || c !== 3'b011) begin
                errors++; $display("FAIL div_rand a=%h b=%h got q=%h r=%h dz=%b lat=%0d ctrl=%b exp q=%h r=%h dz=%b lat=%0d", a, b, r, m, dz, lat, c, er, em, edz, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] r, m; logic dz, bsy; logic [2:0] c; int lat;
        run_op(2'b01, 16'h0050, 16'h0010, 1'b0, lat, r, m, dz, c, bsy);
        checks++;
        if (r !== 16'h0040) begin errors++; $display("FAIL bp_sub got=%h exp=0040", r); end
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_op = 2'b10; req_a = W'($urandom); req_b = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_result, rsp_rem, rsp_divz, req_ready, alu_ctrl, busy} !== {1'b1, 16'h0040, W'(0), 1'b0, 1'b0, 3'b001, 1'b1}) begin
                errors++; $display("FAIL bp_hold cycle=%0d got valid=%b res=%h rem=%h dz=%b rdy=%b ctrl=%b busy=%b exp 1/0040/0000/0/0/001/1", i, rsp_valid, rsp_result, rsp_rem, rsp_divz, req_ready, alu_ctrl, busy);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, busy, alu_ctrl} !== {1'b0, 1'b1, 1'b0, 3'b000}) begin
            errors++; $display("FAIL bp_release got valid=%b rdy=%b busy=%b ctrl=%b exp 0/1/0/000", rsp_valid, req_ready, busy, alu_ctrl);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_no_stale_accept got busy=%b rdy=%b exp 0/1", busy, req_ready); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 14;
        logic [W-1:0] q_res[$], q_rem[$];
        logic         q_dz[$];
        logic [W-1:0] er, em; logic edz;
        int elat, egap, exp_gap;
        int cyc = 0, issued = 0, received = 0, last_acc = -1;
        logic pending;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 2'b10; req_a = W'($urandom); req_b = W'($urandom);
        pending = req_ready;
        exp_gap = 0;
        while (received < N && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== exp_gap) begin
                        errors++; $display("FAIL b2b_gap op#%0d got=%0d exp=%0d", issued, cyc - last_acc, exp_gap);
                    end
                end
                last_acc = cyc;
                ref_op(req_op, req_a, req_b, er, em, edz, elat, egap);
                exp_gap = egap;
                q_res.push_back(er); q_rem.push_back(em); q_dz.push_back(edz);
                issued++;
                if (issued < N) begin
                    req_op = (issued % 2 == 0) ? 2'b10 : ((issued % 3 == 0) ? 2'b01 : 2'b00);
                    req_a = W'($urandom); req_b = W'($urandom);
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (req_ready === busy) begin
                errors++; checks++; $display("FAIL b2b_ready_busy got rdy=%b busy=%b", req_ready, busy);
            end
            if (rsp_valid) begin
                checks++;
                if (q_res.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_rsp got res=%h with no request outstanding", rsp_result);
                end else begin
                    er = q_res.pop_front(); em = q_rem.pop_front(); edz = q_dz.pop_front();
                    if (rsp_result !== er || rsp_rem !== em || rsp_divz !== edz) begin
                        errors++; $display("FAIL b2b_rsp #%0d got res=%h rem=%h dz=%b exp res=%h rem=%h dz=%b", received, rsp_result, rsp_rem, rsp_divz, er, em, edz);
                    end
                end
                received++;
            end
            pending = req_valid && req_ready;
        end
        rsp_ready = 1'b0;
        checks++;
        if (received !== N || issued !== N || q_res.size() !== 0) begin
            errors++; $display("FAIL b2b_count got issued=%0d received=%0d left=%0d exp %0d/%0d/0", issued, received, q_res.size(), N, N);
        end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
